// File: rtl/spi_sram_ctrl.sv
// spi_sram_ctrl: turns 1-4 byte read/write requests into SPI mode-0 frames for a 23LC512 SRAM.
// Define SPI_SRAM_CTRL_MODE_REG_EN to send WRMR (sequential mode) after every reset.
module spi_sram_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    typedef enum logic [2:0] {
`ifdef SPI_SRAM_CTRL_MODE_REG_EN
        INIT,
`endif
        IDLE,
        CMD,
        ADDR,
        DATA,
        GAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  div_cnt;
    logic [15:0] gap_cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  data_idx;
    logic [55:0] shift_out;
    logic        we_q;
    logic [1:0]  size_q;
    logic        mode_op;

    logic shifting;
    logic phase_end;
    logic sck_rise;
    logic bit_end;
    logic bit_last;

    assign shifting  = (state == CMD) || (state == ADDR) || (state == DATA);
    assign phase_end = (div_cnt == DIV_LAST);
    assign sck_rise  = shifting && phase_end && !sck;
    assign bit_end   = shifting && phase_end && sck;
    assign bit_last  = (bit_cnt == 5'd0);

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign cs_n      = !shifting;
    assign mosi      = shifting && shift_out[55];

    always_comb begin
        state_next = state;
        case (state)
`ifdef SPI_SRAM_CTRL_MODE_REG_EN
            INIT: state_next = CMD;
`endif
            IDLE: if (req_valid) state_next = CMD;
            CMD:  if (bit_end && bit_last) state_next = mode_op ? DATA : ADDR;
            ADDR: if (bit_end && bit_last) state_next = DATA;
            DATA: if (bit_end && bit_last) state_next = GAP;
            GAP:  if (gap_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The whole frame (cmd, addr, data bytes in address order) is one MSB-first shift register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
`ifdef SPI_SRAM_CTRL_MODE_REG_EN
            state <= INIT;
`else
            state <= IDLE;
`endif
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            data_idx  <= '0;
            shift_out <= '0;
            we_q      <= 1'b0;
            size_q    <= '0;
            mode_op   <= 1'b0;
            sck       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= 1'b0;
            case (state)
`ifdef SPI_SRAM_CTRL_MODE_REG_EN
                INIT: begin
                    shift_out <= {8'h01, 8'h40, 40'h0};
                    bit_cnt   <= 5'd7;
                    mode_op   <= 1'b1;
                    div_cnt   <= '0;
                    sck       <= 1'b0;
                end
`endif
                IDLE: begin
                    if (req_valid) begin
                        shift_out <= {req_we ? 8'h02 : 8'h03, req_addr,
                                      req_we ? {req_wdata[7:0], req_wdata[15:8],
                                                req_wdata[23:16], req_wdata[31:24]} : 32'h0};
                        bit_cnt   <= 5'd7;
                        data_idx  <= '0;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        mode_op   <= 1'b0;
                        div_cnt   <= '0;
                        sck       <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                    // Read bits land MSB first within the byte lane of the current byte.
                    if (sck_rise && state == DATA && !we_q && !mode_op)
                        rsp_rdata[{data_idx[4:3], ~data_idx[2:0]}] <= miso;
                    if (bit_end) begin
                        shift_out <= {shift_out[54:0], 1'b0};
                        if (state == DATA)
                            data_idx <= data_idx + 5'd1;
                        if (!bit_last)
                            bit_cnt <= bit_cnt - 5'd1;
                        else if (state == CMD)
                            bit_cnt <= mode_op ? 5'd7 : 5'd15;
                        else if (state == ADDR)
                            bit_cnt <= {size_q, 3'b111};
                        else begin
                            gap_cnt   <= '0;
                            rsp_valid <= ~mode_op;
                        end
                    end
                end
                GAP: gap_cnt <= gap_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// tb_spi_sram_ctrl: scoreboard bench for spi_sram_ctrl against a behavioural 23LC512 model.
module tb_spi_sram_ctrl;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso = 1'b0;

    spi_sram_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- SRAM model (sequential mode, SPI mode 0) ----------------
    logic [7:0]  mem [0:65535];
    logic [7:0]  golden [0:65535];
    int          sbit = 0;
    logic [7:0]  s_cmd = '0;
    logic [15:0] s_addr = '0;
    logic [7:0]  s_byte = '0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end

    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            sbit = 0;
        end else begin
            if (sbit < 8) s_cmd = {s_cmd[6:0], mosi};
            else if (sbit < 24) s_addr = {s_addr[14:0], mosi};
            else begin
                s_byte = {s_byte[6:0], mosi};
                if (s_cmd == 8'h02 && (sbit - 24) % 8 == 7)
                    mem[s_addr + 16'((sbit - 24) / 8)] = s_byte;
            end
            sbit++;
        end
    end

    always @(negedge sck) begin
        int d;
        logic [7:0] b;
        if (!cs_n && s_cmd == 8'h03 && sbit >= 24) begin
            d = sbit - 24;
            b = mem[s_addr + 16'(d / 8)];
            miso = b[3'(7 - d % 8)];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int          last_accept = 0;
    int          last_n = 0;
    logic [31:0] last_rdata = '0;

    always @(negedge HCLK) begin
        exp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    int cs_high_run = 0;
    int last_cs_gap = 0;
    always @(negedge HCLK) begin
        if (cs_n) cs_high_run++;
        else begin
            if (cs_high_run != 0) last_cs_gap = cs_high_run;
            cs_high_run = 0;
        end
    end

    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [1:0] size,
                                 input logic [31:0] wdata, input bit hold, input bit expect_rsp);
        exp_t        e;
        logic [31:0] rd;
        logic [15:0] a;
        int          n;
        n = 0;
        while (!req_ready && n < 4000) begin
            @(negedge HCLK);
            n++;
        end
        if (!req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        last_accept = cyc;
        last_n = 24 + 8 * (int'(size) + 1);
        rd = '0;
        for (int k = 0; k <= int'(size); k++) begin
            a = addr + 16'(k);
            if (we) begin
                if (expect_rsp) golden[a] = wdata[8*k +: 8];
            end else begin
                rd[8*k +: 8] = golden[a];
            end
        end
        last_rdata = rd;
        if (expect_rsp) begin
            e.rdata = rd;
            e.cyc   = last_accept + 1 + 2 * CLK_DIV * last_n;
            sb.push_back(e);
        end
        @(negedge HCLK);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!req_ready && n < 4000) begin
            @(negedge HCLK);
            n++;
        end
        checkOutput("ready_cycle", cyc, last_accept + 1 + 2 * CLK_DIV * last_n + CS_GAP);
        checkOutput("rdata_hold", rsp_rdata, last_rdata);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) golden[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;

        repeat (3) @(negedge HCLK);
        checkOutput("rst_outputs", {26'h0, req_ready, busy, sck, cs_n, mosi, rsp_valid},
                    {26'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        checkOutput("rst_rdata", rsp_rdata, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("ready_after_rst", {31'h0, req_ready}, 32'd1);

        // Write then read back, with first-frame timing checks.
        applyStimulus(1'b1, 16'h0100, 2'd3, 32'hDEADBEEF, 1'b0, 1'b1);
        checkOutput("c1_signals", {27'h0, cs_n, mosi, sck, busy, req_ready},
                    {27'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge HCLK);
        checkOutput("sck_low_c2", {31'h0, sck}, 32'd0);
        @(negedge HCLK);
        checkOutput("sck_rise_c3", {31'h0, sck}, 32'd1);
        waitIdle();
        checkOutput("mem_0100", {24'h0, mem[16'h0100]}, 32'hEF);
        checkOutput("mem_0101", {24'h0, mem[16'h0101]}, 32'hBE);
        checkOutput("mem_0102", {24'h0, mem[16'h0102]}, 32'hAD);
        checkOutput("mem_0103", {24'h0, mem[16'h0103]}, 32'hDE);

        applyStimulus(1'b0, 16'h0100, 2'd3, 32'h0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("read4_value", rsp_rdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 16'h0102, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b1);
        waitIdle();
        checkOutput("read1_value", rsp_rdata, 32'h000000AD);

        // Address wrap across 0xFFFF.
        applyStimulus(1'b1, 16'hFFFF, 2'd1, 32'h00001234, 1'b0, 1'b1);
        waitIdle();
        checkOutput("mem_ffff", {24'h0, mem[16'hFFFF]}, 32'h34);
        checkOutput("mem_0000", {24'h0, mem[16'h0000]}, 32'h12);
        applyStimulus(1'b0, 16'h0000, 2'd0, 32'h0, 1'b0, 1'b1);
        waitIdle();

        // Back-to-back reads with req_valid held.
        applyStimulus(1'b0, 16'h0100, 2'd1, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0102, 2'd1, 32'h0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("b2b_cs_gap", last_cs_gap, CS_GAP + 1);

        // Reset during the second data byte of a write.
        applyStimulus(1'b1, 16'h2000, 2'd3, 32'h11223344, 1'b0, 1'b0);
        repeat (134) @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        checkOutput("abort_outputs", {28'h0, cs_n, sck, mosi, rsp_valid},
                    {28'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        checkOutput("abort_rdata", rsp_rdata, 32'h0);
        golden[16'h2000] = 8'h44;
        applyStimulus(1'b0, 16'h2001, 2'd1, 32'h0, 1'b0, 1'b1);
        waitIdle();

        // Random mixed traffic checked against the golden image.
        for (int t = 0; t < 6; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                          2'($urandom_range(0, 3)), $urandom, 1'b0, 1'b1);
            waitIdle();
        end

        repeat (10) @(negedge HCLK);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
